// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller.
package rtc_pkg;

  localparam int unsigned DW          = 8;
  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_PULSO_DEF = 10;
  localparam int unsigned CW_DEF      = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_WR  = 3'd2,
    A_HLD = 3'd3,
    D_SET = 3'd4,
    D_STB = 3'd5,
    D_HLD = 3'd6,
    FIN   = 3'd7
  } rtc_state_e;

  localparam logic OP_LEE     = 1'b0;
  localparam logic OP_ESCRIBE = 1'b1;

  typedef struct packed {
    logic          op;
    logic [DW-1:0] dir;
    logic [DW-1:0] dato;
  } rtc_req_t;

endpackage

// File: rtl/rtc_fase_timer.sv
// Phase counter: counts cycles within a bus phase and flags the terminal count.
module rtc_fase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] tc,
  output logic          fin_fase
);

  logic [CW-1:0] cnt;

  assign fin_fase = (cnt == tc);

  // Restart at zero on every phase boundary so each new state begins at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || fin_fase) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Single-byte read/write sequencer for the RTC multiplexed address/data bus.
// Optional one-entry request buffer enabled with `define RTC_CTRL_QUEUE_EN.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_PULSO = T_PULSO_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          escribe,
  input  logic          lee,
  input  logic [DW-1:0] direccion,
  input  logic [DW-1:0] dato_escribir,
  input  logic [DW-1:0] ad_in,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  output logic          cs_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          a_d,
  output logic [DW-1:0] dato_leido,
  output logic          listo_escribe,
  output logic          listo_lee,
  output logic          ocupado
);

  localparam logic [CW-1:0] TC_SET = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] TC_PUL = CW'(T_PULSO - 1);

  rtc_state_e    state, state_d;
  rtc_req_t      cur, cur_d, req, pend;
  logic          req_vld, pend_vld, pend_take, fin_fase;
  logic [CW-1:0] tc;
  logic [DW-1:0] ad_out_d;
  logic          ad_oe_d, cs_n_d, rd_n_d, wr_n_d, a_d_d;
  logic          listo_escribe_d, listo_lee_d, ocupado_d;

  // Write has priority when both requests arrive together.
  assign req_vld = escribe | lee;
  assign req     = rtc_req_t'{op: (escribe ? OP_ESCRIBE : OP_LEE),
                              dir: direccion, dato: dato_escribir};

  assign pend_take = pend_vld && ((state == IDLE) || (state == FIN));

`ifdef RTC_CTRL_QUEUE_EN
  // A request seen while busy is parked here and launched from FIN or IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld <= 1'b0;
      pend     <= '0;
    end else if (pend_take) begin
      pend_vld <= 1'b0;
    end else if (req_vld && (state != IDLE) && !pend_vld) begin
      pend_vld <= 1'b1;
      pend     <= req;
    end
  end
`else
  assign pend_vld = 1'b0;
  assign pend     = '0;
`endif

  always_comb begin
    tc = '0;
    case (state)
      A_SET, A_HLD, D_SET, D_HLD: tc = TC_SET;
      A_WR, D_STB:                tc = TC_PUL;
      default:                    tc = '0;
    endcase
  end

  rtc_fase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == IDLE),
    .tc       (tc),
    .fin_fase (fin_fase)
  );

  // Next state plus the output values that state will present.
  always_comb begin
    state_d         = state;
    cur_d           = cur;
    ad_out_d        = '0;
    ad_oe_d         = 1'b0;
    cs_n_d          = 1'b1;
    rd_n_d          = 1'b1;
    wr_n_d          = 1'b1;
    a_d_d           = 1'b1;
    listo_escribe_d = 1'b0;
    listo_lee_d     = 1'b0;

    case (state)
      IDLE: begin
        if (pend_take) begin
          state_d = A_SET;
          cur_d   = pend;
        end else if (req_vld) begin
          state_d = A_SET;
          cur_d   = req;
        end
      end
      A_SET:   if (fin_fase) state_d = A_WR;
      A_WR:    if (fin_fase) state_d = A_HLD;
      A_HLD:   if (fin_fase) state_d = D_SET;
      D_SET:   if (fin_fase) state_d = D_STB;
      D_STB:   if (fin_fase) state_d = D_HLD;
      D_HLD:   if (fin_fase) state_d = FIN;
      FIN: begin
        state_d = IDLE;
        if (pend_take) begin
          state_d = A_SET;
          cur_d   = pend;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      A_SET, A_WR, A_HLD: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = cur_d.dir;
        wr_n_d   = (state_d != A_WR);
      end
      D_SET, D_STB, D_HLD: begin
        cs_n_d = 1'b0;
        if (cur_d.op == OP_ESCRIBE) begin
          ad_oe_d  = 1'b1;
          ad_out_d = cur_d.dato;
          wr_n_d   = (state_d != D_STB);
        end else begin
          rd_n_d   = (state_d != D_STB);
        end
      end
      FIN: begin
        listo_escribe_d = (cur_d.op == OP_ESCRIBE);
        listo_lee_d     = (cur_d.op == OP_LEE);
      end
      default: ;
    endcase

    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cur           <= '0;
      ad_out        <= '0;
      ad_oe         <= 1'b0;
      cs_n          <= 1'b1;
      rd_n          <= 1'b1;
      wr_n          <= 1'b1;
      a_d           <= 1'b1;
      listo_escribe <= 1'b0;
      listo_lee     <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      state         <= state_d;
      cur           <= cur_d;
      ad_out        <= ad_out_d;
      ad_oe         <= ad_oe_d;
      cs_n          <= cs_n_d;
      rd_n          <= rd_n_d;
      wr_n          <= wr_n_d;
      a_d           <= a_d_d;
      listo_escribe <= listo_escribe_d;
      listo_lee     <= listo_lee_d;
      ocupado       <= ocupado_d;
    end
  end

  // Sample the pins on the last strobe edge, while rd_n is still low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dato_leido <= '0;
    end else if ((state == D_STB) && fin_fase && (cur.op == OP_LEE)) begin
      dato_leido <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: vector table + scoreboard, plus reset and timing corners.
`timescale 1ns/1ps
module tb_rtc_bus_ctrl;
  import rtc_pkg::*;

  localparam int unsigned TS  = T_SETUP_DEF;
  localparam int unsigned TP  = T_PULSO_DEF;
  localparam int unsigned LAT = 4*TS + 2*TP + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       escribe = 1'b0, lee = 1'b0;
  logic [7:0] direccion = 8'h00, dato_escribir = 8'h00, ad_in = 8'h00;
  logic [7:0] ad_out, dato_leido;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d, listo_escribe, listo_lee, ocupado;

  logic       f_escribe = 1'b0, f_lee = 1'b0;
  logic [7:0] f_direccion = 8'h00, f_dato_escribir = 8'h00, f_ad_in = 8'h00;
  logic [7:0] f_ad_out, f_dato_leido;
  logic       f_ad_oe, f_cs_n, f_rd_n, f_wr_n, f_a_d, f_listo_escribe, f_listo_lee, f_ocupado;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_bus_ctrl dut (
    .clk(clk), .rst(rst), .escribe(escribe), .lee(lee), .direccion(direccion),
    .dato_escribir(dato_escribir), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .dato_leido(dato_leido),
    .listo_escribe(listo_escribe), .listo_lee(listo_lee), .ocupado(ocupado)
  );

  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSO(1), .CW(4)) dut_f (
    .clk(clk), .rst(rst), .escribe(f_escribe), .lee(f_lee), .direccion(f_direccion),
    .dato_escribir(f_dato_escribir), .ad_in(f_ad_in), .ad_out(f_ad_out), .ad_oe(f_ad_oe),
    .cs_n(f_cs_n), .rd_n(f_rd_n), .wr_n(f_wr_n), .a_d(f_a_d), .dato_leido(f_dato_leido),
    .listo_escribe(f_listo_escribe), .listo_lee(f_listo_lee), .ocupado(f_ocupado)
  );

  typedef struct {
    logic       op;
    logic [7:0] dir;
    logic [7:0] dato;
    logic [7:0] dl;
    int         acc;
  } exp_t;

  typedef struct {
    logic       esc;
    logic       le;
    logic [7:0] dir;
    logic [7:0] dato;
    logic [7:0] ad;
    logic       exp_op;
    logic [7:0] exp_dl;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Watches the default instance and scores each completed transaction.
  task automatic monitor();
    int         wr_lo = 0, rd_lo = 0, oe_bad = 0;
    logic [7:0] a_seen = 8'h00, d_seen = 8'h00;
    logic       prev_l = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr_lo = 0; rd_lo = 0; oe_bad = 0; prev_l = 1'b0;
      end else begin
        if (prev_l) chk("listo_width", 32'(listo_escribe | listo_lee), 32'd0);
        if (!wr_n) begin
          wr_lo++;
          if (!a_d) a_seen = ad_out;
          else      d_seen = ad_out;
        end
        if (!rd_n) begin
          rd_lo++;
          if (ad_oe) oe_bad++;
        end
        if (listo_escribe && listo_lee) begin
          chk("listo_both", 32'(listo_lee), 32'd0);
        end else if (listo_escribe || listo_lee) begin
          if (sb.size() == 0) begin
            chk("listo_unexpected", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("op_kind", 32'(listo_escribe), 32'(e.op));
            if (e.acc >= 0) chk("latency", 32'(cyc - e.acc), 32'(LAT));
            chk("addr_phase", 32'(a_seen), 32'(e.dir));
            chk("wr_low_cycles", 32'(wr_lo), e.op ? 32'(2*TP) : 32'(TP));
            chk("rd_low_cycles", 32'(rd_lo), e.op ? 32'd0 : 32'(TP));
            if (e.op) chk("data_phase", 32'(d_seen), 32'(e.dato));
            chk("oe_during_rd", 32'(oe_bad), 32'd0);
            chk("dato_leido", 32'(dato_leido), 32'(e.dl));
          end
          wr_lo = 0; rd_lo = 0; oe_bad = 0;
        end
        prev_l = listo_escribe | listo_lee;
      end
    end
  endtask

  task automatic issue(input logic esc, input logic le, input logic [7:0] d,
                       input logic [7:0] dt, input logic [7:0] a,
                       input logic exp_op, input logic [7:0] exp_dl, input logic track);
    @(negedge clk);
    escribe = esc; lee = le; direccion = d; dato_escribir = dt; ad_in = a;
    sb.push_back(exp_t'{op: exp_op, dir: d, dato: dt, dl: exp_dl, acc: (track ? cyc : -1)});
    @(negedge clk);
    escribe = 1'b0; lee = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (ocupado && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(ocupado), 32'd0);
    @(negedge clk);
  endtask

  task automatic fast_txn(input logic esc, input logic [7:0] d, input logic [7:0] dt,
                          input logic [7:0] a, input logic [7:0] exp_dl);
    int n = 0, lo = 0, run = 0, run_max = 0, t0;
    @(negedge clk);
    f_escribe = esc; f_lee = !esc; f_direccion = d; f_dato_escribir = dt; f_ad_in = a;
    t0 = cyc;
    @(negedge clk);
    f_escribe = 1'b0; f_lee = 1'b0;
    while (!(f_listo_escribe || f_listo_lee) && n < 50) begin
      if (!f_wr_n || !f_rd_n) begin
        lo++; run++;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
      @(negedge clk);
      n++;
    end
    chk("f_done", 32'(f_listo_escribe | f_listo_lee), 32'd1);
    chk("f_kind", 32'(f_listo_escribe), 32'(esc));
    chk("f_latency", 32'(cyc - t0), 32'd7);
    chk("f_strobe_cycles", 32'(lo), 32'd2);
    chk("f_strobe_run", 32'(run_max), 32'd1);
    chk("f_dato_leido", 32'(f_dato_leido), 32'(exp_dl));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dl_model;
    int         n;

    tbl[0] = '{1'b1, 1'b0, 8'h21, 8'h45, 8'h00, OP_ESCRIBE, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h22, 8'h00, 8'h59, OP_LEE,     8'h59};
    tbl[2] = '{1'b1, 1'b0, 8'h7F, 8'hA5, 8'h3C, OP_ESCRIBE, 8'h59};
    tbl[3] = '{1'b1, 1'b1, 8'h10, 8'h33, 8'h77, OP_ESCRIBE, 8'h59};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, OP_LEE,     8'hFF};
    tbl[5] = '{1'b0, 1'b1, 8'h5A, 8'h00, 8'h00, OP_LEE,     8'h00};
    tbl[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3, OP_ESCRIBE, 8'h00};

    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cs_n",    32'(cs_n),    32'd1);
    chk("rst_rd_n",    32'(rd_n),    32'd1);
    chk("rst_wr_n",    32'(wr_n),    32'd1);
    chk("rst_a_d",     32'(a_d),     32'd1);
    chk("rst_ad_oe",   32'(ad_oe),   32'd0);
    chk("rst_ad_out",  32'(ad_out),  32'd0);
    chk("rst_dl",      32'(dato_leido), 32'd0);
    chk("rst_listo",   32'({listo_escribe, listo_lee}), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].esc, tbl[i].le, tbl[i].dir, tbl[i].dato, tbl[i].ad,
            tbl[i].exp_op, tbl[i].exp_dl, 1'b1);
      wait_idle("idle_after_vec");
    end
    dl_model = 8'h00;

    // Read request during a write's address strobe
    issue(1'b1, 1'b0, 8'h40, 8'h9C, 8'h00, OP_ESCRIBE, dl_model, 1'b1);
    repeat (TS) @(negedge clk);
    chk("busy_in_awr", 32'(wr_n), 32'd0);
    lee = 1'b1; direccion = 8'h41; ad_in = 8'h66;
`ifdef RTC_CTRL_QUEUE_EN
    dl_model = 8'h66;
    sb.push_back(exp_t'{op: OP_LEE, dir: 8'h41, dato: 8'h00, dl: 8'h66, acc: -1});
`endif
    @(negedge clk);
    lee = 1'b0;
    wait_idle("idle_after_busy_req");
    chk("busy_req_pending", 32'(sb.size()), 32'd0);
    repeat (40) @(negedge clk);
    chk("no_extra_txn", 32'(ocupado), 32'd0);

    // Async reset in the middle of a read strobe
    issue(1'b0, 1'b1, 8'h30, 8'h00, 8'h11, OP_LEE, 8'h11, 1'b1);
    n = 0;
    while (rd_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_d_stb", 32'(rd_n), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_cs_n",  32'(cs_n),  32'd1);
    chk("arst_rd_n",  32'(rd_n),  32'd1);
    chk("arst_wr_n",  32'(wr_n),  32'd1);
    chk("arst_ad_oe", 32'(ad_oe), 32'd0);
    chk("arst_busy",  32'(ocupado), 32'd0);
    chk("arst_dl",    32'(dato_leido), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dl_model = 8'h00;
    issue(1'b1, 1'b0, 8'h12, 8'hEF, 8'h00, OP_ESCRIBE, dl_model, 1'b1);
    wait_idle("idle_after_reset_write");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Minimum phase lengths on the second instance
    fast_txn(1'b1, 8'h5D, 8'h2E, 8'h00, 8'h00);
    fast_txn(1'b0, 8'h6E, 8'h00, 8'hB4, 8'hB4);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Sequences single-byte read and write transactions on the multiplexed address/data bus of the external RTC chip.
- Produces the `listo_lee` and `listo_escribe` completion pulses that the PicoBlaze input mux samples.
- Holds the last read byte for the `RG*` capture registers.
- Sits between the PicoBlaze output-port decode (request side) and the RTC pins (bus side).

Parameters:
- T_SETUP, 2, clock cycles for each setup/hold phase (min 1)
- T_PULSO, 10, clock cycles `wr_n`/`rd_n` stay low per strobe (min 1)
- CW, 4, internal phase-counter width; must hold max(T_SETUP, T_PULSO)-1

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- escribe  in  1  write request, sampled in IDLE
- lee  in  1  read request, sampled in IDLE
- direccion  in  8  RTC register address, latched on acceptance
- dato_escribir  in  8  write data, latched on acceptance
- ad_in  in  8  bus value read back from the RTC pins
- ad_out  out  8  bus drive value
- ad_oe  out  1  bus output enable (1 = drive `ad_out`)
- cs_n  out  1  RTC chip select, active low
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- a_d  out  1  address/data select (0 = address phase, 1 = data phase)
- dato_leido  out  8  last byte read
- listo_escribe  out  1  1-cycle pulse, write complete
- listo_lee  out  1  1-cycle pulse, read complete
- ocupado  out  1  transaction in progress

Behaviour:
- Reset (async, `rst`=0), applied immediately mid-transaction with no bus completion and no `listo` pulse:
  - `cs_n`=`rd_n`=`wr_n`=`a_d`=1
  - `ad_oe`=0, `ad_out`=0x00
  - `dato_leido`=0x00
  - `listo_*`=0, `ocupado`=0
  - state IDLE, counter 0
- FSM states: IDLE, A_SET, A_WR, A_HLD, D_SET, D_STB, D_HLD, FIN.
- IDLE:
  - `lee` or `escribe` high at an edge → latch `direccion`, `dato_escribir` and the op type, then go to A_SET.
  - Both high together → write wins; the read is dropped.
- Bus outputs per state:
  - A_SET (T_SETUP cycles): `cs_n`=0, `a_d`=0, `ad_oe`=1, `ad_out`=address.
  - A_WR (T_PULSO): as A_SET plus `wr_n`=0.
  - A_HLD (T_SETUP): `wr_n`=1, address still driven.
  - D_SET (T_SETUP): `a_d`=1. Write: `ad_out`=data, `ad_oe`=1. Read: `ad_oe`=0.
  - D_STB (T_PULSO): `wr_n`=0 for a write, `rd_n`=0 for a read. On a read, `ad_in` is captured into `dato_leido` on the last D_STB edge, while `rd_n` is still low.
  - D_HLD (T_SETUP): strobes high; `cs_n`=0 and `ad_oe` unchanged.
  - FIN (1 cycle): `cs_n`=1, `ad_oe`=0, `a_d`=1. `listo_escribe` or `listo_lee`=1 for this single cycle. Next state IDLE.
- Counter:
  - Loads 0 on each state entry.
  - State exits when the counter equals the phase length minus 1.
- Latency: acceptance edge to FIN is 4·T_SETUP + 2·T_PULSO cycles; with defaults, FIN is the 29th cycle after acceptance.
- `ocupado`: 1 in every non-IDLE state, including FIN.
- Requests arriving while not in IDLE are ignored (without the optional feature).
- `dato_leido` holds its value until the next read capture; writes never alter it.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RTC_CTRL_QUEUE_EN.
- Defined:
  - One-entry pending buffer (op, address, data).
  - A request seen while busy with the buffer empty is stored; further requests while it is full are dropped.
  - In FIN with a pending entry, the next state is A_SET with the buffered op; `ocupado` stays 1 and a back-to-back transaction starts with no IDLE cycle.
  - Reset clears the buffer.
- Undefined: the buffer logic is absent and requests while busy are dropped.

Decomposition:
- Shared package `rtc_pkg`:
  - State encoding localparams: 3-bit, IDLE=0 … FIN=7.
  - Op encoding: OP_LEE=0, OP_ESCRIBE=1.
  - Default T_SETUP and T_PULSO constants.
- Sub-module `rtc_fase_timer`: CW-bit phase counter with load-zero and a terminal-count compare input; returns `fin_fase`.

Test Plan:
- Write 0x45 to address 0x21, defaults → `wr_n` low twice for 10 cycles each; `ad_out`=0x21 while `a_d`=0, 0x45 while `a_d`=1; `listo_escribe` pulses once, 29 cycles after acceptance; `dato_leido` unchanged.
- Read address 0x22 with `ad_in`=0x59 during D_STB → `ad_oe`=0 while `rd_n`=0; `dato_leido`=0x59; `listo_lee` single pulse; `listo_escribe` stays 0.
- `lee` and `escribe` high in the same IDLE cycle → only the write is executed; exactly one `listo_escribe` pulse and no `listo_lee`.
- `lee` pulse during a write's A_WR (macro off) → ignored; a single transaction completes. Macro on → read starts directly after FIN, with `ocupado` continuously 1.
- `rst`=0 asserted mid D_STB → `cs_n`/`rd_n`/`wr_n` go 1 and `ad_oe` goes 0 asynchronously; no `listo` pulse; after release, a fresh write completes normally.
- T_SETUP=1, T_PULSO=1 → full transaction takes 7 cycles to FIN; strobes low for exactly 1 cycle.
